// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse train scheduler.
//   - pulse_state_e : FSM state encoding (IDLE/HIGH/LOW/GAP, 2 bits)
//   - tmr_width()   : phase timer width for given HIGH_W/LOW_W/GAP_W
//   - TMR_W         : phase timer width for the default parameter set
//   - RR_LAST_RST   : round-robin pointer reset value (1 => requester 0 wins first)
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } pulse_state_e;

  // Wide enough to hold the largest phase length itself, so no reload value
  // can ever wrap.
  function automatic int tmr_width(input int high_w, input int low_w, input int gap_w);
    int m;
    m = high_w;
    if (low_w > m) m = low_w;
    if (gap_w > m) m = gap_w;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

  localparam int TMR_W = tmr_width(3, 3, 2);

  localparam logic RR_LAST_RST = 1'b1;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter that times one pulse phase.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-high reset (value -> 0)
//   load      in   load load_val this cycle (has priority over counting)
//   load_val  in   W-bit reload value
//   value     out  current count
//   zero      out  value == 0; the counter holds at zero
module pulse_phase_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/pulse_train_scheduler.sv
// Shares one pulse-train output between two requesters. A round-robin
// arbiter picks an owner in IDLE; the FSM then emits count_i pulses, each
// HIGH_W cycles high followed by LOW_W cycles low, and pulses done[owner].
//
// Optional build macro PULSE_SCHED_GAP_EN: inserts a GAP state of GAP_W
// cycles (grant=0, busy=1) after the final low phase; done is issued on
// entry to GAP. Without it, LOW returns straight to IDLE.
//
// Ports:
//   clock      in   system clock, posedge
//   reset      in   synchronous active-high reset
//   req[1:0]   in   request levels, held until the matching done
//   count0/1   in   CNT_W-bit pulse count, sampled at grant; 0 masks the request
//   signal     out  registered pulse-train output
//   grant[1:0] out  one-hot owner of signal, 0 when not bursting
//   busy       out  state != IDLE
//   done[1:0]  out  one-cycle pulse on the owner's bit after the last low phase
//   state_dbg  out  current FSM state for observation
//
// Handshake: a requester raises req[i] with a nonzero count_i and holds it;
// the burst is non-abortable once granted, and done[i] marks completion. The
// next arbitration happens in the done cycle (state is already IDLE).
module pulse_train_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int HIGH_W = 3,
  parameter int LOW_W  = 3,
  parameter int GAP_W  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  output logic             signal,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       done,
  output pulse_state_e     state_dbg
);

  localparam int TW = tmr_width(HIGH_W, LOW_W, GAP_W);
  localparam logic [TW-1:0] HIGH_LD = TW'(HIGH_W - 1);
  localparam logic [TW-1:0] LOW_LD  = TW'(LOW_W - 1);
`ifdef PULSE_SCHED_GAP_EN
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_W - 1);
`endif

  pulse_state_e     state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             signal_q, signal_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             rr_last_q, rr_last_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;

  logic [1:0] eligible;
  logic       winner;

  pulse_phase_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // A zero-count request is masked entirely.
  assign eligible[0] = req[0] && (count0 != '0);
  assign eligible[1] = req[1] && (count1 != '0);

  // Both eligible: the one that did not win last time. Otherwise the lone
  // eligible requester (meaningless when none is eligible; unused then).
  always_comb begin
    if (eligible == 2'b11) begin
      winner = ~rr_last_q;
    end else begin
      winner = ~eligible[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = 2'b00;
    signal_d     = signal_q;
    remaining_d  = remaining_q;
    rr_last_d    = rr_last_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    case (state_q)
      IDLE: begin
        signal_d = 1'b0;
        grant_d  = 2'b00;
        if (eligible != 2'b00) begin
          state_d      = HIGH;
          grant_d      = winner ? 2'b10 : 2'b01;
          signal_d     = 1'b1;
          remaining_d  = winner ? count1 : count0;
          rr_last_d    = winner;
          tmr_load     = 1'b1;
          tmr_load_val = HIGH_LD;
        end
      end

      HIGH: begin
        if (tmr_zero) begin
          state_d      = LOW;
          signal_d     = 1'b0;
          remaining_d  = remaining_q - 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = LOW_LD;
        end
      end

      LOW: begin
        if (tmr_zero) begin
          if (remaining_q != '0) begin
            state_d      = HIGH;
            signal_d     = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = HIGH_LD;
          end else begin
            done_d  = grant_q;
            grant_d = 2'b00;
`ifdef PULSE_SCHED_GAP_EN
            state_d      = GAP;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LD;
`else
            state_d = IDLE;
`endif
          end
        end
      end

`ifdef PULSE_SCHED_GAP_EN
      GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d  = IDLE;
        grant_d  = 2'b00;
        signal_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      signal_q    <= 1'b0;
      remaining_q <= '0;
      rr_last_q   <= RR_LAST_RST;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      signal_q    <= signal_d;
      remaining_q <= remaining_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign signal    = signal_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // The timer value is only consumed through its zero flag.
  logic unused_tmr;
  assign unused_tmr = ^tmr_value;

endmodule

// File: tb/tb_pulse_train_scheduler.sv
module tb_pulse_train_scheduler;
  import pulse_sched_pkg::*;

  localparam int CNT_W  = 4;
  localparam int HIGH_W = 3;
  localparam int LOW_W  = 3;
  localparam int GAP_W  = 2;
  localparam int PULSE  = HIGH_W + LOW_W;
`ifdef PULSE_SCHED_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]       req = 2'b00;
  logic [CNT_W-1:0] count0 = '0;
  logic [CNT_W-1:0] count1 = '0;
  logic             signal;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       done;
  pulse_state_e     state_dbg;

  int checks = 0;
  int errors = 0;
  bit obs_prev;

  pulse_train_scheduler #(
    .CNT_W(CNT_W), .HIGH_W(HIGH_W), .LOW_W(LOW_W), .GAP_W(GAP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .count0    (count0),
    .count1    (count1),
    .signal    (signal),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    req = 2'b00; count0 = '0; count1 = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  // Watches n cycles starting at the current one, then leaves the bench at
  // the cycle after. Counts high cycles, rising edges and premature dones.
  task automatic observe(input int n, output int highs, output int rises, output int early);
    highs = 0; rises = 0; early = 0;
    for (int i = 0; i < n; i++) begin
      if (signal === 1'b1) highs++;
      if (signal === 1'b1 && !obs_prev) rises++;
      obs_prev = (signal === 1'b1);
      if (done !== 2'b00) early++;
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({signal, grant, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sig=%b grant=%b busy=%b done=%b, want all 0",
               signal, grant, busy, done);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
    end
  endtask

  task automatic test_single_burst();
    logic [11:0] exp_pat;
    logic [11:0] got_pat;
    apply_reset();
    exp_pat = 12'b111000111000;
    req = 2'b01; count0 = 4'd2;
    tick();
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%b busy=%b want 01/1", grant, busy);
    end
    for (int i = 0; i < 12; i++) begin
      got_pat[11 - i] = signal;
      tick();
    end
    checks++;
    if (got_pat !== exp_pat) begin
      errors++;
      $display("FAIL single_pattern: got %b want %b", got_pat, exp_pat);
    end
    checks++;
    if (done !== 2'b01 || grant !== 2'b00 || busy !== GAP_EN) begin
      errors++;
      $display("FAIL single_done: got done=%b grant=%b busy=%b want 01/00/%b",
               done, grant, busy, GAP_EN);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("FAIL single_done_width: got done=%b want 00", done);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 2'b11; count0 = 4'd1; count1 = 4'd1;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_grant: got %b want 01", grant);
    end
    tick(PULSE);
    checks++;
    if (done !== 2'b01 || grant !== 2'b00) begin
      errors++;
      $display("FAIL b2b_done0: got done=%b grant=%b want 01/00", done, grant);
    end
    // Keep both requesting: round robin must hand the line to requester 1.
    if (GAP_EN) begin
      for (int i = 0; i < GAP_W; i++) begin
        checks++;
        if (busy !== 1'b1 || grant !== 2'b00) begin
          errors++;
          $display("FAIL b2b_gap_%0d: got busy=%b grant=%b want 1/00", i, busy, grant);
        end
        tick();
      end
      checks++;
      if (busy !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL b2b_gap_idle: got busy=%b grant=%b want 0/00", busy, grant);
      end
    end
    tick();
    checks++;
    if (grant !== 2'b10 || signal !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_grant: got grant=%b sig=%b want 10/1", grant, signal);
    end
    tick(PULSE);
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL b2b_done1: got %b want 10", done);
    end
    req = 2'b00;
    tick(GAP_W + 2);
  endtask

  task automatic test_zero_count();
    int highs, rises, early;
    int bad;
    apply_reset();
    req = 2'b01; count0 = 4'd0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (grant !== 2'b00 || signal !== 1'b0 || busy !== 1'b0 || done !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_count_masked: %0d active cycles, want 0", bad);
    end
    count0 = 4'd3;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL zero_then3_grant: got %b want 01", grant);
    end
    obs_prev = 1'b0;
    observe(3 * PULSE, highs, rises, early);
    checks++;
    if (highs != 3 * HIGH_W || rises != 3 || early != 0) begin
      errors++;
      $display("FAIL count3_shape: highs=%0d rises=%0d early=%0d want %0d/3/0",
               highs, rises, early, 3 * HIGH_W);
    end
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL count3_done: got %b want 01", done);
    end
    req = 2'b00;
    tick(GAP_W + 2);
  endtask

  task automatic test_reset_mid_burst();
    int highs, rises, early;
    apply_reset();
    req = 2'b01; count0 = 4'd4;
    tick();
    tick(PULSE + 1);
    checks++;
    if (signal !== 1'b1 || state_dbg !== HIGH) begin
      errors++;
      $display("FAIL midburst_in_high: got sig=%b state=%0d want 1/%0d", signal, state_dbg, HIGH);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({signal, grant, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL midburst_reset: got sig=%b grant=%b busy=%b done=%b want all 0",
               signal, grant, busy, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL rerequest_grant: got %b want 01", grant);
    end
    obs_prev = 1'b0;
    observe(4 * PULSE, highs, rises, early);
    checks++;
    if (highs != 4 * HIGH_W || rises != 4 || early != 0 || done !== 2'b01) begin
      errors++;
      $display("FAIL rerequest_burst: highs=%0d rises=%0d early=%0d done=%b want %0d/4/0/01",
               highs, rises, early, done, 4 * HIGH_W);
    end
    req = 2'b00;
    tick(GAP_W + 2);
  endtask

  task automatic test_drop_request();
    int h1, r1, e1, h2, r2, e2;
    apply_reset();
    req = 2'b10; count1 = 4'd3;
    tick();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL drop_grant: got %b want 10", grant);
    end
    obs_prev = 1'b0;
    observe(2, h1, r1, e1);
    req = 2'b00; count1 = 4'd7;
    observe(3 * PULSE - 2, h2, r2, e2);
    checks++;
    if (h1 + h2 != 3 * HIGH_W || r1 + r2 != 3 || e1 + e2 != 0) begin
      errors++;
      $display("FAIL drop_shape: highs=%0d rises=%0d early=%0d want %0d/3/0",
               h1 + h2, r1 + r2, e1 + e2, 3 * HIGH_W);
    end
    checks++;
    if (done !== 2'b10 || grant !== 2'b00) begin
      errors++;
      $display("FAIL drop_done: got done=%b grant=%b want 10/00", done, grant);
    end
    tick(GAP_W + 2);
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL drop_no_regrant: got busy=%b grant=%b want 0/00", busy, grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_zero_count();
    test_reset_mid_burst();
    test_drop_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
